// File: rtl/rglib_rotate_out_buf.sv
// Output FIFO behind the rglib rotate unit: no-backpressure capture,
// valid/ready drain, almost-full throttle, sticky overflow.
// Ports: clk, reset (sync, active-high); in_valid/in_data from the
// rotate unit; m_valid/m_data/m_ready to the consumer; almost_full to
// the issuer; count = occupancy; overflow = sticky drop flag;
// drop_cnt = saturating drop counter, built only when the macro
// RGLIB_ROTATE_OUT_BUF_STATS_EN is defined (otherwise tied to 0).
module rglib_rotate_out_buf #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_SLACK = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] SLACK_C = CW'(AFULL_SLACK);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign full = (count == DEPTH_C);
  assign pop  = m_valid & m_ready;
  // A full buffer still takes a result if a slot frees this cycle.
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  assign m_valid     = (count != '0);
  assign m_data      = m_valid ? mem[rd_ptr] : '0;
  assign almost_full = (DEPTH_C - count) <= SLACK_C;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef RGLIB_ROTATE_OUT_BUF_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rglib_rotate_out_buf.sv
// Directed self-checking bench for rglib_rotate_out_buf
// (DEPTH=4, AFULL_SLACK=1, DATA_W=32).
module tb_rglib_rotate_out_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        almost_full;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef RGLIB_ROTATE_OUT_BUF_STATS_EN
  localparam logic [15:0] EXP_DROP2 = 16'd2;
`else
  localparam logic [15:0] EXP_DROP2 = 16'd0;
`endif

  rglib_rotate_out_buf #(
    .DATA_W(32), .DEPTH(4), .AFULL_SLACK(1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    checks++;
    if (count !== 3'd0 || m_valid !== 1'b0 || m_data !== 32'd0 ||
        overflow !== 1'b0 || drop_cnt !== 16'd0 ||
        almost_full !== 1'b0) begin
      errors++;
      $display("FAIL %s: cnt=%0d v=%b d=%h ov=%b dc=%0d af=%b, want all 0",
               nm, count, m_valid, m_data, overflow, drop_cnt,
               almost_full);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    m_ready = 1'b0;
    step();
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic push_n(input int n, input int base);
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = 32'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input logic [31:0] exp[4]);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        errors++;
        $display("FAIL %s[%0d]: v=%b d=%h, want v=1 d=%h",
                 nm, i, m_valid, m_data, exp[i]);
      end
      step();
    end
    m_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: cnt=%0d v=%b, want 0 0",
               nm, count, m_valid);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    do_reset();
    chk_idle("reset");
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; m_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || count !== 3'd1 ||
        m_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_push: v=%b cnt=%0d d=%h, want 1 1 a5a50001",
               m_valid, count, m_data);
    end
    step();
    checks++;
    if (m_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_hold: d=%h, want a5a50001", m_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || count !== 3'd0 || m_data !== 32'd0) begin
      errors++;
      $display("FAIL single_pop: v=%b cnt=%0d d=%h, want 0 0 0",
               m_valid, count, m_data);
    end
  endtask

  task automatic test_fill_order();
    logic [2:0] ec;
    logic       ea;
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      checks++;
      ea = (i >= 3);
      if (count !== 3'(i) || almost_full !== ea) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d af=%b, want %0d %b",
                 i, count, almost_full, i, ea);
      end
    end
    in_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (m_data !== 32'(i)) begin
        errors++;
        $display("FAIL order_%0d: d=%h, want %h", i, m_data, 32'(i));
      end
      step();
      ec = 3'(4 - i);
      ea = (ec >= 3'd3);
      checks++;
      if (count !== ec || almost_full !== ea) begin
        errors++;
        $display("FAIL drain_af_%0d: cnt=%0d af=%b, want %0d %b",
                 i, count, almost_full, ec, ea);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp[4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    push_n(4, 1);
    push_n(2, 5);
    checks++;
    if (count !== 3'd4 || overflow !== 1'b1 || drop_cnt !== EXP_DROP2) begin
      errors++;
      $display("FAIL overflow: cnt=%0d ov=%b dc=%0d, want 4 1 %0d",
               count, overflow, drop_cnt, EXP_DROP2);
    end
    drain("ovf_drain", exp);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ov=%b, want 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp[4] = '{32'd2, 32'd3, 32'd4, 32'd9};
    do_reset();
    push_n(4, 1);
    in_valid = 1'b1; in_data = 32'd9; m_ready = 1'b1;
    step();
    in_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (count !== 3'd4 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL full_pp: cnt=%0d ov=%b dc=%0d, want 4 0 0",
               count, overflow, drop_cnt);
    end
    drain("full_pp_drain", exp);
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'(i) || count !== 3'd1) begin
        errors++;
        $display("FAIL stream_%0d: v=%b d=%h cnt=%0d, want 1 %h 1",
                 i, m_valid, m_data, count, 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    m_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stream_end: cnt=%0d ov=%b dc=%0d, want 0 0 0",
               count, overflow, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    push_n(5, 40);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: cnt=%0d ov=%b, want 3 1", count, overflow);
    end
    do_reset();
    chk_idle("reset_mid");
    in_valid = 1'b1; in_data = 32'h0000_0055;
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || m_data !== 32'h55) begin
      errors++;
      $display("FAIL post_reset_push: cnt=%0d d=%h, want 1 55",
               count, m_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pop: cnt=%0d v=%b, want 0 0",
               count, m_valid);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_order();
    test_overflow();
    test_full_push_pop();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
